qs_srt_fetch_ctrl: RTL and testbench

QS_SRT_FETCH_CTRL -- requirements
Module: qs_srt_fetch_ctrl

---
 rtl/qs_srt_fetch_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_qs_srt_fetch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/qs_srt_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// qs_srt_fetch_ctrl
//
// Instruction fetch sequencer for a micro-coded engine. It walks a program
// counter through an instruction memory that has a fixed 1-cycle read latency.
// It also reacts to decode feedback on every retired instruction: taken jump,
// await-event, done and invalid.
//
// Configuration macro:
//   QS_SRT_FETCH_PERF_EN  When defined, the block builds saturating 32-bit
//                         retire and redirect counters. When undefined, both
//                         perf outputs tie to 0 and no counter flops exist.
//
// Ports:
//   clk             core clock, rising edge
//   rst             synchronous active-high reset
//   start_vld       start request; only honoured in IDLE
//   start_pc        first fetch address
//   fetch_req       imem read strobe
//   fetch_addr      imem read address
//   inst_vld        imem data of this cycle is a live instruction
//   inst_pc         address of that instruction
//   stall           execute backpressure; freezes the pipeline
//   dec_jump_taken  retiring instruction is a taken jump to dec_target
//   dec_target      jump target
//   dec_await       retiring instruction waits for evt_vld
//   dec_done        retiring instruction ends the program
//   dec_invalid     retiring instruction is illegal
//   evt_vld         resume event for AWAIT
//   busy            controller is not IDLE
//   done            one-cycle pulse on program completion
//   err             sticky error; cleared only by rst
//   perf_inst_cnt   retired-instruction count
//   perf_redir_cnt  taken-jump count
// -----------------------------------------------------------------------------
module qs_srt_fetch_ctrl #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_vld,
    input  logic [PC_W-1:0] start_pc,
    output logic            fetch_req,
    output logic [PC_W-1:0] fetch_addr,
    output logic            inst_vld,
    output logic [PC_W-1:0] inst_pc,
    input  logic            stall,
    input  logic            dec_jump_taken,
    input  logic [PC_W-1:0] dec_target,
    input  logic            dec_await,
    input  logic            dec_done,
    input  logic            dec_invalid,
    input  logic            evt_vld,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [31:0]     perf_inst_cnt,
    output logic [31:0]     perf_redir_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_AWAIT = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            inst_vld_q, inst_vld_d;
    logic [PC_W-1:0] inst_pc_q, inst_pc_d;
    logic            done_q, done_d;
    logic            fetch_req_c;
    logic            retire;

    // NOTE: every signal written here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_vld_d  = inst_vld_q;
        inst_pc_d   = inst_pc_q;
        done_d      = 1'b0;
        fetch_req_c = 1'b0;
        retire      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                inst_vld_d = 1'b0;
                if (start_vld) begin
                    pc_d    = start_pc;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // Under stall, all state holds. No fetch is issued and no
                // feedback is consumed.
                if (!stall) begin
                    retire     = inst_vld_q;
                    // Every redirecting event leaves inst_vld_d low. This
                    // kills the slot behind the retiring instruction,
                    // because no fetch is issued in this cycle.
                    inst_vld_d = 1'b0;
                    if (retire && dec_invalid) begin
                        state_d = S_ERROR;
                    end else if (retire && dec_done) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (retire && dec_await) begin
                        state_d = S_AWAIT;
                        pc_d    = inst_pc_q + PC_ONE;
                    end else if (retire && dec_jump_taken) begin
                        pc_d = dec_target;
                    end else begin
                        fetch_req_c = 1'b1;
                        inst_vld_d  = 1'b1;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_q + PC_ONE;
                    end
                end
            end

            S_AWAIT: begin
                inst_vld_d = 1'b0;
                if (evt_vld) begin
                    state_d = S_FETCH;
                end
            end

            S_ERROR: begin
                inst_vld_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            inst_vld_q <= 1'b0;
            inst_pc_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_vld_q <= inst_vld_d;
            inst_pc_q  <= inst_pc_d;
            done_q     <= done_d;
        end
    end

    // The strobe is gated by rst. A fetch is then never presented while the
    // controller is being reset.
    assign fetch_req  = fetch_req_c & ~rst;
    assign fetch_addr = pc_q;
    assign inst_vld   = inst_vld_q;
    assign inst_pc    = inst_pc_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = (state_q == S_ERROR);

`ifdef QS_SRT_FETCH_PERF_EN
    logic [31:0] perf_inst_q;
    logic [31:0] perf_redir_q;
    logic        redir_evt;

    // A redirect counts only when the jump wins the event priority.
    assign redir_evt = retire & dec_jump_taken & ~dec_invalid & ~dec_done & ~dec_await;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_q  <= '0;
            perf_redir_q <= '0;
        end else begin
            if (retire && (perf_inst_q != 32'hFFFF_FFFF)) begin
                perf_inst_q <= perf_inst_q + 32'd1;
            end
            if (redir_evt && (perf_redir_q != 32'hFFFF_FFFF)) begin
                perf_redir_q <= perf_redir_q + 32'd1;
            end
        end
    end

    assign perf_inst_cnt  = perf_inst_q;
    assign perf_redir_cnt = perf_redir_q;
`else
    assign perf_inst_cnt  = 32'd0;
    assign perf_redir_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_qs_srt_fetch_ctrl.sv
module tb_qs_srt_fetch_ctrl;

    localparam int PC_W = 10;
`ifdef QS_SRT_FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start_vld;
    logic [PC_W-1:0] start_pc;
    logic            fetch_req;
    logic [PC_W-1:0] fetch_addr;
    logic            inst_vld;
    logic [PC_W-1:0] inst_pc;
    logic            stall;
    logic            dec_jump_taken;
    logic [PC_W-1:0] dec_target;
    logic            dec_await;
    logic            dec_done;
    logic            dec_invalid;
    logic            evt_vld;
    logic            busy;
    logic            done;
    logic            err;
    logic [31:0]     perf_inst_cnt;
    logic [31:0]     perf_redir_cnt;

    int checks = 0;
    int errors = 0;

    qs_srt_fetch_ctrl #(.PC_W(PC_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_vld      (start_vld),
        .start_pc       (start_pc),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .inst_vld       (inst_vld),
        .inst_pc        (inst_pc),
        .stall          (stall),
        .dec_jump_taken (dec_jump_taken),
        .dec_target     (dec_target),
        .dec_await      (dec_await),
        .dec_done       (dec_done),
        .dec_invalid    (dec_invalid),
        .evt_vld        (evt_vld),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .perf_inst_cnt  (perf_inst_cnt),
        .perf_redir_cnt (perf_redir_cnt)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then changed and
    // outputs sampled 1ns later, well away from either edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_vld = 1'b0; start_pc = '0; stall = 1'b0;
        dec_jump_taken = 1'b0; dec_target = '0; dec_await = 1'b0;
        dec_done = 1'b0; dec_invalid = 1'b0; evt_vld = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        settle();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_fetch_req got %0b exp 0", fetch_req); end
        checks++; if (fetch_addr !== 10'h000) begin errors++; $display("FAIL reset_fetch_addr got %0h exp 0", fetch_addr); end
        checks++; if (inst_vld !== 1'b0) begin errors++; $display("FAIL reset_inst_vld got %0b exp 0", inst_vld); end
        checks++; if (inst_pc !== 10'h000) begin errors++; $display("FAIL reset_inst_pc got %0h exp 0", inst_pc); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_busy_done_err got %03b exp 000", {busy, done, err}); end
        checks++; if (perf_inst_cnt !== 32'd0 || perf_redir_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_inst_cnt, perf_redir_cnt); end
    endtask

    // Sequential fetch from 0x010, then a taken jump at 0x012 to 0x040.
    task automatic test_fetch_and_jump();
        start_vld = 1'b1; start_pc = 10'h010;
        settle();
        checks++; if (fetch_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_c0_idle got req=%0b busy=%0b exp 0/0", fetch_req, busy); end
        cyc(); start_vld = 1'b0; settle();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 10'h010) begin errors++; $display("FAIL basic_c1_fetch got %0b@%0h exp 1@010", fetch_req, fetch_addr); end
        checks++; if (inst_vld !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_c1_state got vld=%0b busy=%0b exp 0/1", inst_vld, busy); end
        cyc(); settle();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 10'h011) begin errors++; $display("FAIL basic_c2_fetch got %0b@%0h exp 1@011", fetch_req, fetch_addr); end
        checks++; if (inst_vld !== 1'b1 || inst_pc !== 10'h010) begin errors++; $display("FAIL basic_c2_inst got %0b@%0h exp 1@010", inst_vld, inst_pc); end
        cyc(); settle();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 10'h012) begin errors++; $display("FAIL basic_c3_fetch got %0b@%0h exp 1@012", fetch_req, fetch_addr); end
        checks++; if (inst_vld !== 1'b1 || inst_pc !== 10'h011) begin errors++; $display("FAIL basic_c3_inst got %0b@%0h exp 1@011", inst_vld, inst_pc); end
        cyc();
        dec_jump_taken = 1'b1; dec_target = 10'h040;
        settle();
        checks++; if (inst_vld !== 1'b1 || inst_pc !== 10'h012) begin errors++; $display("FAIL jump_retire_inst got %0b@%0h exp 1@012", inst_vld, inst_pc); end
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL jump_retire_req got %0b exp 0", fetch_req); end
        cyc(); dec_jump_taken = 1'b0; dec_target = '0; settle();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 10'h040) begin errors++; $display("FAIL jump_target_fetch got %0b@%0h exp 1@040", fetch_req, fetch_addr); end
        checks++; if (inst_vld !== 1'b0) begin errors++; $display("FAIL jump_bubble got %0b exp 0", inst_vld); end
        cyc(); settle();
        checks++; if (inst_vld !== 1'b1 || inst_pc !== 10'h040) begin errors++; $display("FAIL jump_target_inst got %0b@%0h exp 1@040", inst_vld, inst_pc); end
        checks++; if (perf_redir_cnt !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL jump_perf_redir got %0d exp %0d", perf_redir_cnt, PERF ? 1 : 0); end
        checks++; if (perf_inst_cnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL jump_perf_inst got %0d exp %0d", perf_inst_cnt, PERF ? 3 : 0); end
    endtask

    // 0x040 jumps to 0x020; 0x020 is held under a 3-cycle stall.
    task automatic test_stall();
        dec_jump_taken = 1'b1; dec_target = 10'h020;
        cyc(); dec_jump_taken = 1'b0; dec_target = '0;
        cyc(); stall = 1'b1; settle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL stall_req_%0d got %0b exp 0", i, fetch_req); end
            checks++; if (inst_vld !== 1'b1 || inst_pc !== 10'h020) begin errors++; $display("FAIL stall_inst_%0d got %0b@%0h exp 1@020", i, inst_vld, inst_pc); end
            cyc();
            if (i == 2) stall = 1'b0;
            settle();
        end
        // The stalled cycle issued nothing, so fetching resumes at the held pc.
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 10'h021) begin errors++; $display("FAIL stall_resume_fetch got %0b@%0h exp 1@021", fetch_req, fetch_addr); end
        checks++; if (inst_vld !== 1'b1 || inst_pc !== 10'h020) begin errors++; $display("FAIL stall_resume_inst got %0b@%0h exp 1@020", inst_vld, inst_pc); end
        cyc(); settle();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 10'h022) begin errors++; $display("FAIL stall_next_fetch got %0b@%0h exp 1@022", fetch_req, fetch_addr); end
        checks++; if (inst_vld !== 1'b1 || inst_pc !== 10'h021) begin errors++; $display("FAIL stall_next_inst got %0b@%0h exp 1@021", inst_vld, inst_pc); end
    endtask

    // 0x021 jumps to 0x030; 0x030 awaits; an early evt_vld is ignored.
    task automatic test_await();
        dec_jump_taken = 1'b1; dec_target = 10'h030;
        cyc(); dec_jump_taken = 1'b0; dec_target = '0; evt_vld = 1'b1;
        cyc(); evt_vld = 1'b0; dec_await = 1'b1; settle();
        checks++; if (inst_vld !== 1'b1 || inst_pc !== 10'h030 || fetch_req !== 1'b0) begin errors++; $display("FAIL await_retire got vld=%0b pc=%0h req=%0b exp 1/030/0", inst_vld, inst_pc, fetch_req); end
        for (int i = 1; i <= 5; i++) begin
            cyc();
            dec_await = 1'b0;
            if (i == 2) begin start_vld = 1'b1; start_pc = 10'h100; end
            else start_vld = 1'b0;
            if (i == 5) evt_vld = 1'b1;
            settle();
            checks++; if (fetch_req !== 1'b0 || inst_vld !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL await_wait_%0d got req=%0b vld=%0b busy=%0b exp 0/0/1", i, fetch_req, inst_vld, busy); end
        end
        cyc(); evt_vld = 1'b0; settle();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 10'h031) begin errors++; $display("FAIL await_resume_fetch got %0b@%0h exp 1@031", fetch_req, fetch_addr); end
        cyc(); dec_done = 1'b1;
        cyc(); dec_done = 1'b0; settle();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL await_done got done=%0b busy=%0b exp 1/0", done, busy); end
    endtask

    // Fetch from 0x3FF wraps to 0x000; 0x000 retires with dec_done.
    task automatic test_wrap_done();
        cyc(); start_vld = 1'b1; start_pc = 10'h3FF;
        cyc(); start_vld = 1'b0; start_pc = '0; settle();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_fetch_top got %0b@%0h exp 1@3ff", fetch_req, fetch_addr); end
        cyc(); settle();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 10'h000) begin errors++; $display("FAIL wrap_fetch_zero got %0b@%0h exp 1@000", fetch_req, fetch_addr); end
        checks++; if (inst_vld !== 1'b1 || inst_pc !== 10'h3FF) begin errors++; $display("FAIL wrap_inst_top got %0b@%0h exp 1@3ff", inst_vld, inst_pc); end
        cyc(); dec_done = 1'b1; settle();
        checks++; if (inst_pc !== 10'h000 || fetch_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL wrap_done_retire got pc=%0h req=%0b done=%0b exp 000/0/0", inst_pc, fetch_req, done); end
        cyc(); dec_done = 1'b0; settle();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || inst_vld !== 1'b0 || fetch_req !== 1'b0) begin errors++; $display("FAIL wrap_done_pulse got done=%0b busy=%0b vld=%0b req=%0b exp 1/0/0/0", done, busy, inst_vld, fetch_req); end
        checks++; if (perf_inst_cnt !== (PERF ? 32'd10 : 32'd0) || perf_redir_cnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL wrap_perf got %0d/%0d exp %0d/%0d", perf_inst_cnt, perf_redir_cnt, PERF ? 10 : 0, PERF ? 3 : 0); end
        cyc(); settle();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wrap_done_width got %0b exp 0", done); end
    endtask

    // dec_invalid outranks dec_done; ERROR ignores start_vld and leaves only on rst.
    task automatic test_error();
        start_vld = 1'b1; start_pc = 10'h050;
        cyc(); start_vld = 1'b0;
        cyc(); dec_invalid = 1'b1; dec_done = 1'b1; settle();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL err_retire_req got %0b exp 0", fetch_req); end
        cyc(); dec_invalid = 1'b0; dec_done = 1'b0; start_vld = 1'b1; start_pc = 10'h080; settle();
        checks++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL err_enter got err=%0b done=%0b busy=%0b exp 1/0/1", err, done, busy); end
        cyc(); start_vld = 1'b0; settle();
        checks++; if (err !== 1'b1 || fetch_req !== 1'b0 || inst_vld !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL err_sticky got err=%0b req=%0b vld=%0b done=%0b exp 1/0/0/0", err, fetch_req, inst_vld, done); end
        rst = 1'b1;
        cyc(); rst = 1'b0; settle();
        checks++; if (err !== 1'b0 || busy !== 1'b0 || fetch_req !== 1'b0) begin errors++; $display("FAIL err_reset got err=%0b busy=%0b req=%0b exp 0/0/0", err, busy, fetch_req); end
    endtask

    // rst while a fetch is in flight: no inst_vld on the following cycle.
    task automatic test_reset_midop();
        start_vld = 1'b1; start_pc = 10'h060;
        cyc(); start_vld = 1'b0;
        cyc(); rst = 1'b1; settle();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL midrst_req_in_rst got %0b exp 0", fetch_req); end
        cyc(); rst = 1'b0; settle();
        checks++; if (inst_vld !== 1'b0 || inst_pc !== 10'h000) begin errors++; $display("FAIL midrst_inst got %0b@%0h exp 0@000", inst_vld, inst_pc); end
        checks++; if (fetch_req !== 1'b0 || fetch_addr !== 10'h000 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state got req=%0b addr=%0h busy=%0b exp 0/000/0", fetch_req, fetch_addr, busy); end
        checks++; if (perf_inst_cnt !== 32'd0 || perf_redir_cnt !== 32'd0) begin errors++; $display("FAIL midrst_perf got %0d/%0d exp 0/0", perf_inst_cnt, perf_redir_cnt); end
    endtask

    initial begin
        test_reset();
        test_fetch_and_jump();
        test_stall();
        test_await();
        test_wrap_done();
        test_error();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
